// File: rtl/nes_scan_doubler.sv
// nes_scan_doubler: PPU-to-VGA scan converter with 2C02 palette ROM and ping-pong line buffers.
// Define NES_SCANLINES_EN to halve every channel on odd VGA lines.
module nes_scan_doubler #(
    parameter int LINE_W    = 256,
    parameter int VIS_LINES = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ppu_valid,
    input  logic [7:0]  ppu_x,
    input  logic [8:0]  ppu_y,
    input  logic [5:0]  ppu_color,
    input  logic [9:0]  next_pixel_x,
    output logic [14:0] pixel,
    output logic        vga_sync,
    output logic        locked
);
    localparam int         AW      = $clog2(LINE_W);
    localparam logic [8:0] VIS_Y   = 9'(VIS_LINES);
    localparam logic [8:0] LAST_Y  = 9'd261;
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // 2C02 palette as {b,g,r}; blacks and the dark mirror entries fall to the default.
    function automatic logic [14:0] pal_lookup(input logic [5:0] idx);
        case (idx)
            6'h00: return 15'h39CE;  6'h01: return 15'h4464;  6'h02: return 15'h5400;  6'h03: return 15'h4C08;
            6'h04: return 15'h3811;  6'h05: return 15'h0815;  6'h06: return 15'h0014;  6'h07: return 15'h002F;
            6'h08: return 15'h00A8;  6'h09: return 15'h0100;  6'h0A: return 15'h0140;  6'h0B: return 15'h08E0;
            6'h0C: return 15'h2CE3;  6'h10: return 15'h5EF7;  6'h11: return 15'h75C0;  6'h12: return 15'h74E4;
            6'h13: return 15'h7810;  6'h14: return 15'h5C17;  6'h15: return 15'h2C1C;  6'h16: return 15'h0C17;
            6'h17: return 15'h0539;  6'h18: return 15'h01D1;  6'h19: return 15'h0240;  6'h1A: return 15'h02A0;
            6'h1B: return 15'h1E40;  6'h1C: return 15'h4600;  6'h20: return 15'h7FFF;  6'h21: return 15'h7EE7;
            6'h22: return 15'h7E4B;  6'h23: return 15'h7E39;  6'h24: return 15'h7DFE;  6'h25: return 15'h59DF;
            6'h26: return 15'h31DF;  6'h27: return 15'h1E7F;  6'h28: return 15'h1EFE;  6'h29: return 15'h0B50;
            6'h2A: return 15'h2769;  6'h2B: return 15'h4FEB;  6'h2C: return 15'h6FA0;  6'h30: return 15'h7FFF;
            6'h31: return 15'h7F95;  6'h32: return 15'h7F58;  6'h33: return 15'h7F3A;  6'h34: return 15'h7F1F;
            6'h35: return 15'h6F1F;  6'h36: return 15'h5AFF;  6'h37: return 15'h577F;  6'h38: return 15'h539F;
            6'h39: return 15'h53FC;  6'h3A: return 15'h5FD5;  6'h3B: return 15'h67F6;  6'h3C: return 15'h7BF3;
            6'h3D: return 15'h6318;
            default: return 15'h0000;
        endcase
    endfunction

    logic [1:0]    r_state;
    logic          r_locked;
    logic          r_vga_sync;
    logic          r_rd_bank;
    logic [8:0]    r_last_y;
    logic          r_wr_en;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_addr;
    logic [14:0]   r_wr_rgb;
    logic [14:0]   r_rd_data;
    logic [14:0]   r_line_buf [2*LINE_W];

    logic          w_accept;
    logic          w_line_start;
    logic          w_lost;
    logic          w_sync_trig;
    logic [14:0]   w_shaded;

    assign w_accept     = ppu_valid && (ppu_y < VIS_Y);
    assign w_line_start = w_accept && (ppu_x == 8'd0);
    // A backwards step in ppu_y is only legal as the 261 -> 0 frame wrap.
    assign w_lost       = ppu_valid && (ppu_y < r_last_y) && !((r_last_y == LAST_Y) && (ppu_y == 9'd0));
    assign w_sync_trig  = w_line_start && (ppu_y == 9'd1) && !w_lost
                          && ((r_state == ST_FILL) || (r_state == ST_RUN));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_WAIT;
            r_locked   <= 1'b0;
            r_vga_sync <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_last_y   <= 9'd0;
            r_wr_en    <= 1'b0;
        end else begin
            r_wr_en    <= w_accept;
            r_vga_sync <= w_sync_trig;
            if (ppu_valid) r_last_y <= ppu_y;
            if (w_line_start) r_rd_bank <= ~ppu_y[0];
            if (w_lost) begin
                r_state  <= ST_WAIT;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_WAIT: if (w_line_start && (ppu_y == 9'd0)) r_state <= ST_FILL;
                    ST_FILL: if (w_sync_trig) begin
                        r_state  <= ST_RUN;
                        r_locked <= 1'b1;
                    end
                    ST_RUN:  r_state <= ST_RUN;
                    default: r_state <= ST_WAIT;
                endcase
            end
        end
    end

    // NOTE: the line buffer and its write pipeline carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr_bank <= ppu_y[0];
            r_wr_addr <= ppu_x[AW-1:0];
            r_wr_rgb  <= pal_lookup(ppu_color);
        end
        if (r_wr_en) r_line_buf[{r_wr_bank, r_wr_addr}] <= r_wr_rgb;
        r_rd_data <= r_line_buf[{r_rd_bank, next_pixel_x[AW:1]}];
    end

`ifdef NES_SCANLINES_EN
    logic r_odd_line;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_odd_line <= 1'b0;
        else          r_odd_line <= next_pixel_x[9];
    end

    assign w_shaded = r_odd_line ? {1'b0, r_rd_data[14:11], 1'b0, r_rd_data[9:6], 1'b0, r_rd_data[4:1]}
                                 : r_rd_data;
`else
    logic w_unused_parity;
    assign w_unused_parity = next_pixel_x[9];
    assign w_shaded        = r_rd_data;
`endif

    assign pixel    = r_locked ? w_shaded : 15'h0000;
    assign vga_sync = r_vga_sync;
    assign locked   = r_locked;

endmodule

// File: doc/nes_scan_doubler.md
# nes_scan_doubler

Line-buffer scan converter between the PPU pixel stream and the VGA output stage. It palette-converts each PPU pixel to 15-bit RGB and stores it in a ping-pong pair of 256-entry line buffers. It returns the pixel addressed by the VGA stage's `next_pixel_x` one cycle later, and issues a once-per-frame `vga_sync` pulse that locks VGA line 0 to PPU scanline 0.

## Interface
Parameters:
- `LINE_W`, default 256: visible PPU pixels per scanline. Sets the buffer depth.
- `VIS_LINES`, default 240: visible PPU scanlines. Writes at `ppu_y >= VIS_LINES` are ignored.

Ports:
- `clk`  in  1: single clock, shared with the VGA stage. VGA dot rate, 2x PPU dot rate.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ppu_valid`  in  1: one-cycle strobe. A PPU pixel is presented this cycle.
- `ppu_x`  in  8: pixel column, 0..255.
- `ppu_y`  in  9: scanline, 0..261.
- `ppu_color`  in  6: 2C02 palette index.
- `next_pixel_x`  in  10: pixel the VGA stage needs next cycle. Bit 9 is VGA line parity; bits 8:0 are the VGA column 0..511.
- `pixel`  out  15: RGB as {b[4:0], g[4:0], r[4:0]}.
- `vga_sync`  out  1: one-cycle pulse that restarts VGA counters at h=0, v=0.
- `locked`  out  1: high once the first full visible line has been buffered.

## Operation
- Palette stage:
  - On `ppu_valid` with `ppu_y < VIS_LINES`, register `{bank=ppu_y[0], addr=ppu_x, rgb=PAL[ppu_color]}`.
  - Write the buffer on the following cycle.
  - The PAL table is fixed ROM, 64 entries, standard 2C02. Pinned entries: 0x0F/0x1D/0x2D-dark/0x3F → 15'h0000; 0x30 → 15'h7FFF; 0x16 → 15'h0C17.
- Read bank: `rd_bank` is latched as `!ppu_y[0]` on every accepted write with `ppu_x == 0`. Reading always targets the line not being written.
- Read address: `{rd_bank, next_pixel_x[8:1]}`. Each PPU pixel is shown twice horizontally. Each PPU line covers two VGA lines, because one PPU line equals two VGA line periods.
- The read is a synchronous RAM read, registered into `pixel`.
- FSM, 3 states:
  - WAIT, the reset state: stays until an accepted write with `ppu_x==0, ppu_y==0` → FILL.
  - FILL: stays until a write with `ppu_x==0, ppu_y==1` → RUN. On that transition assert `vga_sync` and set `locked`.
  - RUN: re-issue `vga_sync` on every write with `ppu_x==0, ppu_y==1`, i.e. once per frame.
  - Any state: seeing `ppu_y` decrease without passing 261→0 (lost frame) → WAIT, and clear `locked`.
- While `locked==0`, `pixel` is forced to 0.
- Buffer conflicts: the two sides never use the same bank in RUN. A write to the bank being read has no defined priority; it cannot occur in RUN.

## Timing
- Reset values: `pixel`=0, `vga_sync`=0, `locked`=0, FSM=WAIT, `rd_bank`=0. Buffer contents are undefined.
- Write latency: the write lands 1 cycle after `ppu_valid`.
- Read latency: `next_pixel_x` sampled at cycle N → `pixel` valid at cycle N+1. Exactly 1 cycle, with no stalls.
- `vga_sync` is registered. It goes high for exactly 1 cycle, the cycle after the triggering write strobe.
- `locked` rises in the same cycle as the first `vga_sync`.
- Reset asserted mid-line: all outputs return to their reset values immediately (asynchronous). No `vga_sync` is produced until FILL→RUN completes again.
- Simultaneous `ppu_valid` and sync trigger: the write and the sync pulse both occur; neither is dropped.

## Configuration
- `NES_SCANLINES_EN` defined: when the registered `next_pixel_x[9]` is 1 (odd VGA line), each 5-bit channel of `pixel` is right-shifted by 1. Example: 15'h7FFF → 15'h3DEF.
- `NES_SCANLINES_EN` undefined: `pixel` is the buffer value unmodified on all lines. No extra logic is present.

## Test plan
- Reset, then `next_pixel_x`=0x010 → `pixel`=0, `locked`=0, no `vga_sync` for 1000 cycles.
- Write line 0 all 0x30, then strobe (x=0,y=1) → `vga_sync` is a 1-cycle pulse 1 cycle later and `locked`=1. `next_pixel_x`=0x000..0x1FF returns 15'h7FFF, each with 1-cycle latency.
- Line 0 with `ppu_color`=x[5:0] → `next_pixel_x`=2k and 2k+1 both return PAL[k]; k=0x16 gives 15'h0C17.
- Writes with `ppu_y`=240..261 must not alter the buffered line. Line 239's data is read back unchanged.
- Jump `ppu_y` from 100 to 5 → `locked`=0, `pixel`=0. Relock with a fresh `vga_sync` only after y=0 then y=1.
- Build with `NES_SCANLINES_EN`: 0x30 pixel on `next_pixel_x[9]`=1 → 15'h3DEF, and on bit 9=0 → 15'h7FFF. Build without it → 15'h7FFF on both.
